lzss_ram_clear_seq: RTL and testbench

Parametrised memory-clear sequencer for the LZSS stage: replaces the single-flag, single-cap RAM reset with a multi-channel sweep engine. Drives the write ports of up to NUM_CH on-chip RAMs (ll_symbols, distance_symbols, lzss_output, …) with a fill value over an address range. Runs automatically after reset and on request with a per-channel mask. Optionally reads the range back and flags mismatches.

---
 rtl/lzss_ram_clear_seq_if.sv | 41 ++++
 rtl/lzss_ram_clear_seq.sv | 181 ++++++++++++++++++
 tb/tb_lzss_ram_clear_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/lzss_ram_clear_seq_if.sv
// Control and RAM-port bundle for lzss_ram_clear_seq.
// Read-back and error signals exist only when LZSS_CLEAR_VERIFY_EN is defined.
interface lzss_ram_clear_seq_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                     start;
    logic [NUM_CH-1:0]        ch_mask;
    logic [ADDR_W-1:0]        cap;
    logic                     busy;
    logic                     done;
    logic [NUM_CH-1:0]        wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
`ifdef LZSS_CLEAR_VERIFY_EN
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic [NUM_CH*DATA_W-1:0] rd_data;
    logic                     verify_err;
    logic [NUM_CH-1:0]        err_ch;

    modport master (
        output start, ch_mask, cap, rd_data,
        input  busy, done, wr_en, wr_addr, wr_data, rd_en, rd_addr, verify_err, err_ch
    );
    modport slave (
        input  start, ch_mask, cap, rd_data,
        output busy, done, wr_en, wr_addr, wr_data, rd_en, rd_addr, verify_err, err_ch
    );
`else
    modport master (
        output start, ch_mask, cap,
        input  busy, done, wr_en, wr_addr, wr_data
    );
    modport slave (
        input  start, ch_mask, cap,
        output busy, done, wr_en, wr_addr, wr_data
    );
`endif
endinterface

// File: rtl/lzss_ram_clear_seq.sv
// Multi-channel RAM clear sequencer for the LZSS stage; optional read-back check
// is compiled in with LZSS_CLEAR_VERIFY_EN.
//
// state  | meaning
// IDLE   | waiting for auto-clear pending flag or start
// CLEAR  | writing FILL_VALUE to addresses 0..cap on masked channels
// VERIFY | reading 0..cap back, plus one drain beat for the last read
// DONE   | one busy cycle before returning to IDLE (done pulses then)
module lzss_ram_clear_seq #(
    parameter int                NUM_CH     = 4,
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] FILL_VALUE = '0,
    parameter bit                AUTO_CLEAR = 1'b1
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    lzss_ram_clear_seq_if.slave s_if
);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_VERIFY, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [NUM_CH-1:0] r_mask, w_mask_nxt;
    logic [ADDR_W-1:0] r_cap, w_cap_nxt;
    logic              r_pending, w_pending_nxt;
    logic              w_accept;
    logic [CNT_W-1:0]  w_cap_ext;

    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [NUM_CH-1:0] r_wr_en, w_wr_en_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;

`ifdef LZSS_CLEAR_VERIFY_EN
    logic              r_rd_en, w_rd_en_nxt;
    logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
    logic              r_rd_vld;
    logic [NUM_CH-1:0] r_err, w_err_nxt;
    logic              r_verify_err;
`endif

    assign w_cap_ext = {1'b0, r_cap};
    assign w_accept  = (r_state == S_IDLE) && (r_pending || s_if.start);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mask    <= '0;
            r_cap     <= '0;
            r_pending <= AUTO_CLEAR;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_nxt;
            r_mask    <= w_mask_nxt;
            r_cap     <= w_cap_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_cnt_nxt     = r_cnt;
        w_mask_nxt    = r_mask;
        w_cap_nxt     = r_cap;
        w_pending_nxt = r_pending;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next        = S_CLEAR;
                    w_cnt_nxt     = '0;
                    w_pending_nxt = 1'b0;
                    if (r_pending) begin
                        w_mask_nxt = '1;
                        w_cap_nxt  = '1;
                    end else begin
                        // An empty mask still spends one write-less CLEAR beat,
                        // so its done latency equals that of a cap=0 sweep.
                        w_mask_nxt = s_if.ch_mask;
                        w_cap_nxt  = (s_if.ch_mask == '0) ? '0 : s_if.cap;
                    end
                end
            end
            S_CLEAR: begin
                if (r_cnt == w_cap_ext) begin
                    w_cnt_nxt = '0;
`ifdef LZSS_CLEAR_VERIFY_EN
                    w_next    = (r_mask != '0) ? S_VERIFY : S_DONE;
`else
                    w_next    = S_DONE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_VERIFY: begin
                if (r_cnt == w_cap_ext + CNT_W'(1)) begin
                    w_next = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with the state they describe.
    always_comb begin
        w_busy_nxt    = (w_next != S_IDLE);
        w_done_nxt    = (r_state == S_DONE) && (w_next == S_IDLE);
        w_wr_en_nxt   = '0;
        w_wr_addr_nxt = '0;
        if (w_next == S_CLEAR) begin
            w_wr_en_nxt   = w_mask_nxt;
            w_wr_addr_nxt = w_cnt_nxt[ADDR_W-1:0];
        end
`ifdef LZSS_CLEAR_VERIFY_EN
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = '0;
        if ((w_next == S_VERIFY) && (w_cnt_nxt <= {1'b0, w_cap_nxt})) begin
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = w_cnt_nxt[ADDR_W-1:0];
        end
        w_err_nxt = r_err;
        if (w_accept) begin
            w_err_nxt = '0;
        end else if (r_rd_vld) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (r_mask[c] && (s_if.rd_data[c*DATA_W +: DATA_W] != FILL_VALUE)) begin
                    w_err_nxt[c] = 1'b1;
                end
            end
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wr_en      <= '0;
            r_wr_addr    <= '0;
`ifdef LZSS_CLEAR_VERIFY_EN
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_vld     <= 1'b0;
            r_err        <= '0;
            r_verify_err <= 1'b0;
`endif
        end else begin
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
`ifdef LZSS_CLEAR_VERIFY_EN
            r_rd_en      <= w_rd_en_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_rd_vld     <= r_rd_en;
            r_err        <= w_err_nxt;
            r_verify_err <= |w_err_nxt;
`endif
        end
    end

    assign s_if.busy    = r_busy;
    assign s_if.done    = r_done;
    assign s_if.wr_en   = r_wr_en;
    assign s_if.wr_addr = r_wr_addr;
    assign s_if.wr_data = FILL_VALUE;
`ifdef LZSS_CLEAR_VERIFY_EN
    assign s_if.rd_en      = r_rd_en;
    assign s_if.rd_addr    = r_rd_addr;
    assign s_if.err_ch     = r_err;
    assign s_if.verify_err = r_verify_err;
`endif
endmodule

// File: tb/tb_lzss_ram_clear_seq.sv
// Scoreboard bench for lzss_ram_clear_seq (NUM_CH=4, ADDR_W=4, AUTO_CLEAR=1).
module tb_lzss_ram_clear_seq;
    localparam int          NUM_CH = 4;
    localparam int          ADDR_W = 4;
    localparam int          DATA_W = 32;
    localparam logic [31:0] FILL   = 32'h0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lzss_ram_clear_seq_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lzss_ram_clear_seq #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FILL_VALUE(FILL), .AUTO_CLEAR(1'b1)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .s_if   (bus)
    );

    typedef struct {int cyc; logic [3:0] mask; logic [3:0] addr;} wr_exp_t;
    typedef struct {int cyc; logic [3:0] err;} done_exp_t;
    wr_exp_t   wq[$];
    done_exp_t dq[$];

`ifdef LZSS_CLEAR_VERIFY_EN
    // RAM models; channel 1 address 2 is stuck at 32'h1 on read.
    logic [31:0] mem [NUM_CH][16];
    initial begin
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < 16; a++) mem[c][a] = 32'hDEAD_BEEF;
    end
    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.wr_en[c]) mem[c][bus.wr_addr] <= bus.wr_data;
            if (bus.rd_en)
                bus.rd_data[c*32 +: 32] <= (c == 1 && bus.rd_addr == 4'd2) ? 32'h1 : mem[c][bus.rd_addr];
        end
    end
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc + 1);
        end
    endtask

    function automatic int done_lat(input logic [3:0] m, input int c);
        if (m == 4'd0) return 3;
`ifdef LZSS_CLEAR_VERIFY_EN
        return 5 + 2 * c;
`else
        return 3 + c;
`endif
    endfunction

    function automatic logic [3:0] exp_err(input logic [3:0] m, input int c);
        return (m[1] && c >= 2) ? 4'b0010 : 4'b0000;
    endfunction

    // Monitor: cycle number of the interval after edge n is n+1.
    always @(negedge clk) begin
        wr_exp_t   e;
        done_exp_t d;
        if (rst_n) begin
            if (bus.wr_en != '0) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", 64'(bus.wr_en), 64'd0);
                end else begin
                    e = wq.pop_front();
                    chk("wr_cycle", 64'(cyc + 1), 64'(e.cyc));
                    chk("wr_en",    64'(bus.wr_en), 64'(e.mask));
                    chk("wr_addr",  64'(bus.wr_addr), 64'(e.addr));
                    chk("wr_data",  64'(bus.wr_data), 64'(FILL));
                end
            end
            if (bus.done) begin
                if (dq.size() == 0) begin
                    chk("done_unexpected", 64'(bus.done), 64'd0);
                end else begin
                    d = dq.pop_front();
                    chk("done_cycle",   64'(cyc + 1), 64'(d.cyc));
                    chk("busy_at_done", 64'(bus.busy), 64'd0);
`ifdef LZSS_CLEAR_VERIFY_EN
                    chk("err_ch",     64'(bus.err_ch), 64'(d.err));
                    chk("verify_err", 64'(bus.verify_err), 64'(|d.err));
`endif
                end
            end
        end
    end

    task automatic drive_start(input logic [3:0] m, input logic [3:0] c, output int t);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.ch_mask = m;
        bus.cap     = c;
        t = cyc + 1;
    endtask

    task automatic release_start();
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic expect_sweep(input int t, input logic [3:0] m, input int c,
                                input int nwr, input bit do_done);
        for (int a = 0; a < nwr; a++) wq.push_back('{t + 1 + a, m, 4'(a)});
        if (do_done) dq.push_back('{t + done_lat(m, c), exp_err(m, c)});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((wq.size() != 0 || dq.size() != 0 || bus.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 64'(wq.size() + dq.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, t2, dl;
        bus.start   = 1'b0;
        bus.ch_mask = '0;
        bus.cap     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",    64'(bus.busy), 64'd0);
        chk("rst_done",    64'(bus.done), 64'd0);
        chk("rst_wr_en",   64'(bus.wr_en), 64'd0);
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);

        // Auto sweep after release: all channels, addresses 0..15
        @(negedge clk);
        rst_n = 1'b1;
        t = cyc + 1;
        expect_sweep(t, 4'hF, 15, 16, 1'b1);
        wait_idle();

        // Partial mask, cap=5: done at T+8 in the default build
        drive_start(4'b0101, 4'd5, t);
        expect_sweep(t, 4'b0101, 5, 6, 1'b1);
        release_start();
        wait_idle();

        drive_start(4'b0010, 4'd3, t);
        expect_sweep(t, 4'b0010, 3, 4, 1'b1);
        release_start();
        wait_idle();

        drive_start(4'b0110, 4'd1, t);
        expect_sweep(t, 4'b0110, 1, 2, 1'b1);
        release_start();
        wait_idle();

        // Empty mask: no writes, done at T+3
        drive_start(4'b0000, 4'd7, t);
        expect_sweep(t, 4'b0000, 7, 0, 1'b1);
        release_start();
        wait_idle();

        // Second start while busy is dropped
        drive_start(4'b0011, 4'd9, t);
        expect_sweep(t, 4'b0011, 9, 10, 1'b1);
        release_start();
        repeat (2) @(negedge clk);
        chk("busy_mid", 64'(bus.busy), 64'd1);
        drive_start(4'b1111, 4'd2, t2);
        release_start();
        wait_idle();

        // Reset at address 3 of a cap=9 sweep, then auto sweep restarts at 0
        drive_start(4'b0101, 4'd9, t);
        expect_sweep(t, 4'b0101, 9, 4, 1'b0);
        release_start();
        while (cyc + 1 < t + 4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy",    64'(bus.busy), 64'd0);
        chk("abort_wr_en",   64'(bus.wr_en), 64'd0);
        chk("abort_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("abort_done",    64'(bus.done), 64'd0);
        chk("abort_pending_writes", 64'(wq.size()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t = cyc + 1;
        expect_sweep(t, 4'hF, 15, 16, 1'b1);
        wait_idle();

        // Back-to-back: start held through the done cycle of a cap=2 sweep
        drive_start(4'b0001, 4'd2, t);
        expect_sweep(t, 4'b0001, 2, 3, 1'b1);
        dl = done_lat(4'b0001, 2);
        while (cyc + 1 < t + dl) @(negedge clk);
        bus.ch_mask = 4'b1000;
        bus.cap     = 4'd3;
        t2 = cyc + 1;
        expect_sweep(t2, 4'b1000, 3, 4, 1'b1);
        release_start();
        wait_idle();

        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("dq_empty", 64'(dq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
